// File: rtl/axi_rd_pkg.sv
// +--------------------------------------------------------------------+
// | axi_rd_pkg : shared types for the AXI read-data responder          |
// | Rev 1.0    : initial release                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package axi_rd_pkg;

  // Width of the data field in the output-FIFO entry; the responder's
  // DATA_WIDTH must match it.
  localparam int unsigned AXI_RD_DATA_WIDTH = 32;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [AXI_RD_DATA_WIDTH-1:0] data;
    logic [1:0]                   resp;
    logic                         last;
  } rd_entry_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_out_fifo.sv
// +--------------------------------------------------------------------+
// | axi_rd_out_fifo : 2-entry synchronous FIFO of R-channel beats      |
// | Rev 1.0         : initial release                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module axi_rd_out_fifo
  import axi_rd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rd_entry_t push_entry,
  input  logic      pop,
  output rd_entry_t pop_entry,
  output logic      full,
  output logic      empty
);

  rd_entry_t  mem_q [2];
  rd_entry_t  mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign pop_entry = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_rd_data_responder.sv
// +--------------------------------------------------------------------+
// | axi_rd_data_responder : turns burst commands into INCR memory      |
// |   reads and returns them as AXI R-channel beats.                   |
// | Optional: AXI_RD_RANGE_CHECK_EN (SLVERR for addr >= MEM_DEPTH)     |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module axi_rd_data_responder
  import axi_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = AXI_RD_DATA_WIDTH,
  parameter int unsigned ID_MAX_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MEM_DEPTH    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ID_MAX_WIDTH-1:0] cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_MAX_WIDTH-1:0] rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    ruser
);

  if ((64'(MEM_DEPTH) > (64'd1 << ADDR_WIDTH)) || (DATA_WIDTH != AXI_RD_DATA_WIDTH)) begin : g_cfg_check
    $error("axi_rd_data_responder: MEM_DEPTH or DATA_WIDTH out of range");
  end

  rd_state_e              state_q, state_d;
  logic [ID_MAX_WIDTH-1:0] id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              rem_q, rem_d;
  logic                    iss_done_q, iss_done_d;
  logic                    infl_q, infl_d;
  logic                    infl_last_q, infl_last_d;
  logic                    infl_err_q, infl_err_d;

  logic       range_err;
  logic       issue;
  logic [1:0] fifo_cnt, occ;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       rvalid_int, r_hs;
  rd_entry_t  ret_entry, fifo_head, head_entry;

`ifdef AXI_RD_RANGE_CHECK_EN
  assign range_err = ({1'b0, addr_q} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
`else
  assign range_err = 1'b0;
`endif

  // Reads are only launched when every returning word is guaranteed a FIFO slot.
  assign fifo_cnt = {fifo_full, !fifo_full && !fifo_empty};
  assign occ      = fifo_cnt + {1'b0, infl_q};
  assign issue    = !rst && (state_q == BURST) && !iss_done_q && (occ < 2'd2);

  assign mem_rd_en   = issue && !range_err;
  assign mem_rd_addr = addr_q;

  assign ret_entry.data = infl_err_q ? '0 : mem_rd_data;
  assign ret_entry.resp = infl_err_q ? RRESP_SLVERR : RRESP_OKAY;
  assign ret_entry.last = infl_last_q;

  // Returning data bypasses an empty FIFO so the first beat appears at T+2.
  assign head_entry = fifo_empty ? ret_entry : fifo_head;
  assign rvalid_int = !fifo_empty || infl_q;
  assign r_hs       = rvalid && rready;
  assign fifo_push  = infl_q && !(fifo_empty && rready);
  assign fifo_pop   = !fifo_empty && rready;

  assign cmd_ready = !rst && (state_q == IDLE);
  assign rvalid    = !rst && rvalid_int;
  assign rid       = rst ? '0 : id_q;
  assign rdata     = rvalid ? head_entry.data : '0;
  assign rresp     = rvalid ? head_entry.resp : RRESP_OKAY;
  assign rlast     = rvalid && head_entry.last;
  assign ruser     = 1'b0;

  axi_rd_out_fifo u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (ret_entry),
    .pop        (fifo_pop),
    .pop_entry  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    iss_done_d  = iss_done_q;
    infl_d      = issue;
    infl_last_d = issue && (rem_q == 8'd0);
    infl_err_d  = issue && range_err;
    if (issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - 8'd1;
      if (rem_q == 8'd0) begin
        iss_done_d = 1'b1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = BURST;
          id_d       = cmd_id;
          addr_d     = cmd_addr;
          rem_d      = cmd_len;
          iss_done_d = 1'b0;
        end
      end
      BURST: begin
        if (r_hs && head_entry.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      rem_q       <= 8'd0;
      iss_done_q  <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      iss_done_q  <= iss_done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      infl_err_q  <= infl_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_data_responder.sv
// +--------------------------------------------------------------------+
// | tb_axi_rd_data_responder : directed bench with a mem[i]=i model    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_axi_rd_data_responder;

  localparam int DW = 32;
  localparam int IW = 12;
  localparam int AW = 10;
`ifdef AXI_RD_RANGE_CHECK_EN
  localparam int DEPTH = 1000;
`else
  localparam int DEPTH = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          ruser;

  int n_checks = 0;
  int n_pass   = 0;

  axi_rd_data_responder #(
    .DATA_WIDTH   (DW),
    .ID_MAX_WIDTH (IW),
    .ADDR_WIDTH   (AW),
    .MEM_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_id      (cmd_id),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .rvalid      (rvalid),
    .rready      (rready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .ruser       (ruser)
  );

  always #5 clk = ~clk;

  // Memory holds mem[i] = i; junk when not read so stale data is visible.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? {22'd0, mem_rd_addr} : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit oor(input logic [AW-1:0] a);
`ifdef AXI_RD_RANGE_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: rready always high; mode 1: rready 1,0,0 repeating from T+2
  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input int mode, input string name);
    int            beats, iss, last_cyc;
    bit            done;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_iss [$];
    exp_iss = {};
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + AW'(i);
      if (!oor(a)) exp_iss.push_back(a);
    end
    check({name, " cmd_ready idle"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    rready    = 1'b0;
    tick;
    cmd_valid = 1'b0;
    check({name, " cmd_ready busy"}, cmd_ready, 0);
    check({name, " rvalid T+1"}, rvalid, 0);
    beats = 0; iss = 0; done = 0; last_cyc = 0;
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      rready = (mode == 0) ? 1'b1 : (cyc >= 2 && ((cyc - 2) % 3) == 0);
      if (mem_rd_en) begin
        if (iss < exp_iss.size()) check({name, " mem_rd_addr"}, mem_rd_addr, exp_iss[iss]);
        else check({name, " extra read"}, iss, exp_iss.size());
        iss++;
      end
      if (cyc == 2 && mode == 0) check({name, " rvalid T+2"}, rvalid, 1);
      if (rvalid) begin
        if (beats <= int'(len)) begin
          a = addr + AW'(beats);
          check({name, " rdata"}, rdata, oor(a) ? 32'd0 : {22'd0, a});
          check({name, " rid"}, rid, id);
          check({name, " rresp"}, rresp, oor(a) ? 2'b10 : 2'b00);
          check({name, " rlast"}, rlast, beats == int'(len));
        end else begin
          check({name, " extra beat"}, beats, int'(len) + 1);
        end
        if (rready) begin
          beats++;
          if (rlast) begin
            done = 1;
            last_cyc = cyc;
          end
        end
      end
      tick;
    end
    rready = 1'b0;
    check({name, " beat count"}, beats, int'(len) + 1);
    check({name, " read count"}, iss, exp_iss.size());
    if (mode == 0) check({name, " throughput"}, last_cyc, int'(len) + 2);
    check({name, " cmd_ready after last"}, cmd_ready, 1);
    check({name, " rvalid after last"}, rvalid, 0);
  endtask

  initial begin
    tick;
    tick;
    check("rst cmd_ready", cmd_ready, 0);
    check("rst rvalid", rvalid, 0);
    check("rst mem_rd_en", mem_rd_en, 0);
    check("rst rdata", rdata, 0);
    check("rst rid", rid, 0);
    check("rst rlast", rlast, 0);
    check("rst rresp", rresp, 0);
    rst = 1'b0;
    #1;
    check("cmd_ready after rst", cmd_ready, 1);
    check("ruser", ruser, 0);

    run_burst(12'd5, 10'h010, 8'd3, 0, "len3");
    run_burst(12'd1, 10'h020, 8'd0, 0, "len0");
    run_burst(12'd2, 10'h080, 8'd7, 1, "stall");
    run_burst(12'd3, 10'h3FE, 8'd3, 0, "wrap");

    // Reset in the middle of an 8-beat burst
    cmd_valid = 1'b1; cmd_id = 12'd3; cmd_addr = 10'h040; cmd_len = 8'd7; rready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("mid beat0", rdata, 32'h40);
    tick;
    check("mid beat1", rdata, 32'h41);
    tick;
    check("mid beat2", rdata, 32'h42);
    rst = 1'b1;
    #1;
    check("mid rst rvalid", rvalid, 0);
    check("mid rst mem_rd_en", mem_rd_en, 0);
    tick;
    rst = 1'b0;
    #1;
    check("post rst rvalid", rvalid, 0);
    check("post rst cmd_ready", cmd_ready, 1);
    tick;
    check("post rst idle rvalid", rvalid, 0);
    rready = 1'b0;
    run_burst(12'd9, 10'h100, 8'd1, 0, "id9");

`ifdef AXI_RD_RANGE_CHECK_EN
    run_burst(12'd4, 10'd998, 8'd3, 0, "range");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_rd_data_responder.md
AXI_RD_DATA_RESPONDER -- requirements
Module: axi_rd_data_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, R-channel data width in bits.
REQ-002 SHALL have parameter ID_MAX_WIDTH, default 12, RID width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, word address width of the backing memory port.
REQ-004 SHALL have parameter MEM_DEPTH, default 1024, number of valid words (at most 2**ADDR_WIDTH).
REQ-005 SHALL have one clock and a synchronous active-high reset, in this port order:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have these command ports:
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_id  in  ID_MAX_WIDTH  burst ID.
- cmd_addr  in  ADDR_WIDTH  start word address.
- cmd_len  in  8  beats minus one (AXI ARLEN semantics).
REQ-007 SHALL have these memory ports:
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  memory word address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-008 SHALL have these R-channel ports (slave side):
- rvalid  out  1  beat valid.
- rready  in  1  beat accepted when high with rvalid.
- rid  out  ID_MAX_WIDTH  ID of the current burst.
- rdata  out  DATA_WIDTH  beat data.
- rresp  out  2  beat response.
- rlast  out  1  final beat of the burst.
- ruser  out  1  tied 0.

Function
REQ-009 SHALL use a 2-state FSM: IDLE, BURST.
REQ-010 IDLE: SHALL assert cmd_ready=1; on cmd_valid, latch id/addr/len, load beat counter = cmd_len, and go to BURST.
REQ-011 BURST: SHALL hold cmd_ready=0 and issue one INCR read per cycle (mem_rd_addr = latched addr + beat index, modulo 2**ADDR_WIDTH) while the output buffer has space.
REQ-012 SHALL hold read data in a 2-entry output FIFO. A read SHALL be issued only when (entries occupied + reads in flight) < 2, so rready backpressure never loses data.
REQ-013 rvalid SHALL be high whenever the FIFO is non-empty. rdata/rid/rresp/rlast SHALL be stable while rvalid=1 and rready=0.
REQ-014 Latency: command accepted at cycle T gives mem_rd_en at T+1 and first rvalid at T+2.
REQ-015 With rready held high, SHALL sustain one beat per cycle.
REQ-016 rlast SHALL be 1 only on beat cmd_len (cmd_len=0 gives a single beat with rlast=1).
REQ-017 Transition BURST->IDLE SHALL happen when the rlast beat handshakes. cmd_ready SHALL rise the next cycle (no command overlap).
REQ-018 Address wrap: addr 2**ADDR_WIDTH-1 SHALL be followed by 0.
REQ-019 Without the REQ-023 feature, rresp SHALL always be 2'b00 (OKAY).

Reset
REQ-020 While rst=1: FSM=IDLE, FIFO and in-flight state cleared, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_rd_en=0, cmd_ready=0.
REQ-021 cmd_ready SHALL go high the first cycle after rst deasserts.
REQ-022 Reset mid-burst SHALL abandon the burst with no further beats, and SHALL discard the mem_rd_data returning after reset.

Configuration
REQ-023 Macro AXI_RD_RANGE_CHECK_EN. When defined, a beat whose address >= MEM_DEPTH SHALL NOT assert mem_rd_en for that beat; it SHALL return rdata=0, rresp=2'b10 (SLVERR), and keep its position and rlast.
REQ-024 When AXI_RD_RANGE_CHECK_EN is undefined, SHALL apply no range check, always return rresp=OKAY, and read every address.

Structure
REQ-025 A shared package axi_rd_pkg SHALL hold the FSM state enum (IDLE, BURST), the RRESP constants (OKAY=2'b00, SLVERR=2'b10), and the FIFO entry struct {data, resp, last}.
REQ-026 SHALL instantiate one sub-module, axi_rd_out_fifo: a 2-entry synchronous FIFO with push/pop/full/empty.

Verification
REQ-027 cmd_len=3, addr=0x010, id=5, rready=1, mem[i]=i -> rvalid at T+2, 4 consecutive beats with rdata 0x10..0x13, rid=5, rlast on 4th beat.
REQ-028 cmd_len=0 -> exactly one beat with rlast=1; cmd_ready high again the cycle after that handshake.
REQ-029 cmd_len=7 with rready toggling 1,0,0,1,... -> all 8 beats delivered in order, none dropped or duplicated, and outputs stable while stalled.
REQ-030 addr=0x3FE, cmd_len=3 -> mem_rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-031 rst asserted on beat 2 of an 8-beat burst -> rvalid=0 next cycle; new cmd id=9 afterward returns only id=9 data.
REQ-032 With AXI_RD_RANGE_CHECK_EN and MEM_DEPTH=1000: addr=998, cmd_len=3 -> rresp OKAY, OKAY, SLVERR, SLVERR, and the last two beats have rdata=0.
